// File: rtl/vram_write_buffer_m_pkg.sv
// Shared definitions for the VRAM write buffer: address width, renderer region bases
// and the status state encoding.
package vram_write_buffer_m_pkg;

   localparam int VRAM_ADDR_WIDTH = 12;

   localparam logic [VRAM_ADDR_WIDTH-1:0] PMF_BASE  = 12'h000;
   localparam logic [VRAM_ADDR_WIDTH-1:0] OBM_BASE  = 12'h400;
   localparam logic [VRAM_ADDR_WIDTH-1:0] PMB_BASE  = 12'h800;
   localparam logic [VRAM_ADDR_WIDTH-1:0] NTBL_BASE = 12'hC00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      HOLD  = 2'd2
   } wb_state_t;

endpackage

// File: rtl/vram_write_buffer_m_fifo.sv
// Show-ahead synchronous FIFO with registered occupancy count and full flag.
// The head entry is readable combinationally from storage.
module vram_write_buffer_m_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, full_d;
   logic             push_ok, pop_ok;

   // A push while full is refused even if a pop happens in the same cycle.
   assign push_ok = push_i && !full_q;
   assign pop_ok  = pop_i && (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
      count_d  = count_q;
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      full_d = (count_d == CNT_W'(DEPTH));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign full_o  = full_q;
   assign count_o = count_q;

endmodule

// File: rtl/vram_write_buffer_m.sv
// CPU-to-VRAM write buffer: queues CPU byte writes and replays them in order only
// while the video timing reports a writable window.
module vram_write_buffer_m
   import vram_write_buffer_m_pkg::*;
#(
   parameter int ADDR_W = VRAM_ADDR_WIDTH,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cpu_we_i,
   input  logic [ADDR_W-1:0]        cpu_addr_i,
   input  logic [7:0]               cpu_data_i,
   output logic                     cpu_ready_o,
   input  logic                     writable_i,
   output logic                     vram_we_o,
   output logic [ADDR_W-1:0]        vram_addr_o,
   output logic [7:0]               vram_data_o,
   output logic [$clog2(DEPTH):0]   pending_o,
   output logic                     overflow_o,
   input  logic                     ovf_clear_i,
   output wb_state_t                state_o
);

   localparam int ENTRY_W = ADDR_W + 8;
   localparam int CNT_W   = $clog2(DEPTH) + 1;

   logic [ENTRY_W-1:0] head;
   logic               empty, full;
   logic [CNT_W-1:0]   count;
   logic               push, pop, drop;
   logic               empty_next;
   logic               overflow_q, overflow_d;
   wb_state_t          state_q, state_d;

   assign push = cpu_we_i && !full;
   assign pop  = writable_i && !empty;
   assign drop = cpu_we_i && full;

   vram_write_buffer_m_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i ({cpu_addr_i, cpu_data_i}),
      .rdata_o (head),
      .empty_o (empty),
      .full_o  (full),
      .count_o (count)
   );

   // Occupancy after this edge decides IDLE versus a busy state.
   assign empty_next = ((count == '0) && !push) ||
                       ((count == CNT_W'(1)) && pop && !push);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (empty_next) begin
         state_d = IDLE;
      end else if (writable_i) begin
         state_d = DRAIN;
      end else begin
         state_d = HOLD;
      end
   end

   // Storage is never reset, so the head is masked while empty to keep outputs defined.
   always_comb begin
      vram_we_o   = pop;
      vram_addr_o = '0;
      vram_data_o = '0;
      if (!empty) begin
         vram_addr_o = head[ENTRY_W-1:8];
         vram_data_o = head[7:0];
      end
   end

   always_comb begin
      overflow_d = overflow_q;
      if (drop) begin
         overflow_d = 1'b1;
      end else if (ovf_clear_i) begin
         overflow_d = 1'b0;
      end
   end

   assign cpu_ready_o = !full;
   assign pending_o   = count;
   assign overflow_o  = overflow_q;
   assign state_o     = state_q;

endmodule
